pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Sequences exception/eret flushes, deferring a flush while a memory access is still stalled.
- Keeps a saturating stall-cycle counter and a stall watchdog.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect address for all exceptions except eret
ERET_TYPE, 32'h0000_000e, excp_type code meaning eret (redirect to cp0_epc)
WDOG_LIMIT, 1024, consecutive stalled cycles before wdog_timeout sets (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stallreq_if  input  1  fetch stage waiting on instruction memory
stallreq_id  input  1  decode stage load-use hazard
stallreq_ex  input  1  execute stage multi-cycle op busy
stallreq_mem  input  1  memory stage waiting on data memory
excp_type  input  32  nonzero = exception raised at MEM this cycle
cp0_epc  input  32  current EPC from CP0
stall  output  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = hold
flush  output  1  clear all pipeline registers this cycle
new_pc  output  32  redirect target, valid when flush=1
stall_cycles  output  32  count of cycles with stall[0]=1
wdog_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: state=RUN, latched type/epc=0, stall_cycles=0, wd_cnt=0, wdog_timeout=0.
- While rst=1: stall=6'b0, flush=0, new_pc=0, regardless of inputs.
- stall, flush and new_pc are combinational from the registered state, the latched values and the current inputs. Zero-cycle latency.
- States: RUN, PEND.
- RUN, excp_type!=0 and stallreq_mem=0:
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc if excp_type==ERET_TYPE, else EXC_VECTOR.
  - Stay in RUN.
  - Back-to-back exceptions each produce their own one-cycle flush.
- RUN, excp_type!=0 and stallreq_mem=1:
  - Latch excp_type and cp0_epc.
  - stall=6'b011111, flush=0.
  - Next state PEND.
- RUN, excp_type==0: flush=0, new_pc=0. Stall priority is highest stage wins:
  - stallreq_mem -> 6'b011111
  - else stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else stallreq_if -> 6'b000011
  - else 6'b000000
- PEND:
  - excp_type and the lower-stage requests are ignored.
  - While stallreq_mem=1: stall=6'b011111, flush=0.
  - First cycle stallreq_mem=0: flush=1, stall=0, new_pc computed from the latched type/epc. Next state RUN.
- stall_cycles: +1 on each cycle with stall[0]=1. Saturates at 32'hFFFF_FFFF and never wraps.
- Watchdog:
  - wd_cnt +1 on each cycle with stall[0]=1.
  - wd_cnt clears on any cycle with stall[0]=0 or flush=1.
  - When wd_cnt reaches WDOG_LIMIT, wdog_timeout is set to 1 on the following edge and stays set until rst.
  - wd_cnt saturates at WDOG_LIMIT.
- rst asserted in PEND: return to RUN, drop the pending exception. No flush is emitted.
- An exception and a stall request in the same RUN cycle without stallreq_mem: the exception wins and the stall request is dropped for that cycle.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then all requests 0 -> stall=0, flush=0, stall_cycles=0, wdog_timeout=0.
2. Priority: stallreq_if=1 and stallreq_ex=1 together -> stall=6'b001111; drop ex -> 6'b000011; assert mem alone -> 6'b011111. stall_cycles equals the number of stalled cycles.
3. Immediate exception: excp_type=32'h0000_0008, stallreq_mem=0 -> same-cycle flush=1, new_pc=32'h0000_0020, stall=0. Next cycle flush=0.
4. eret: excp_type=32'h0000_000e, cp0_epc=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234.
5. Deferred exception: stallreq_mem=1 for 3 cycles and excp_type=8 in the first; cp0_epc changes afterward.
   - Stalled cycles: stall=6'b011111, flush=0.
   - First cycle after stallreq_mem falls: flush=1, new_pc=EXC_VECTOR.
   - Repeat with eret: new_pc is the epc latched at entry, not the changed value.
   - Assert rst during PEND -> no flush, state RUN.
6. Watchdog with WDOG_LIMIT=4:
   - stallreq_ex held 3 cycles then released -> wdog_timeout stays 0.
   - Held 5 cycles -> wdog_timeout=1 and stays 1 after release until rst.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with stall-cycle counter and watchdog
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_TYPE  = 32'h0000_000e,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excp_type,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        wdog_timeout
);
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(WDOG_LIMIT);
  typedef enum logic {RUN, PEND} state_t;
  state_t state, state_n;
  logic [31:0] lat_type, lat_epc;
  logic ld;
  logic [WW-1:0] wd_cnt;
  // next state, stall vector and flush/redirect from state, latched exception and live requests
  always_comb begin
    state_n = state;
    stall = '0;
    flush = 1'b0;
    new_pc = '0;
    ld = 1'b0;
    if (!rst) begin
      if (state == PEND) begin
        stall = stallreq_mem ? 6'b011111 : 6'b000000;
        flush = !stallreq_mem;
        new_pc = stallreq_mem ? '0 : (lat_type == ERET_TYPE ? lat_epc : EXC_VECTOR);
        state_n = stallreq_mem ? PEND : RUN;
      end else if (excp_type != '0) begin
        ld = stallreq_mem;
        stall = stallreq_mem ? 6'b011111 : 6'b000000;
        flush = !stallreq_mem;
        new_pc = stallreq_mem ? '0 : (excp_type == ERET_TYPE ? cp0_epc : EXC_VECTOR);
        state_n = stallreq_mem ? PEND : RUN;
      end else begin
        stall = stallreq_mem ? 6'b011111 :
                stallreq_ex  ? 6'b001111 :
                stallreq_id  ? 6'b000111 :
                stallreq_if  ? 6'b000011 : 6'b000000;
      end
    end
  end
  // state, deferred-exception latch, saturating counters and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      lat_type <= '0;
      lat_epc <= '0;
      stall_cycles <= '0;
      wd_cnt <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (ld) begin
        lat_type <= excp_type;
        lat_epc <= cp0_epc;
      end
      if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      wd_cnt <= (stall[0] && !flush) ? (wd_cnt == WD_MAX ? wd_cnt : wd_cnt + WW'(1)) : '0;
      if (wd_cnt == WD_MAX) wdog_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with per-cycle reference model comparison
module tb_pipe_ctrl;
  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam logic [31:0] ERET = 32'h0000_000e;
  localparam int LIM = 4;
  logic clk = 0, rst = 1;
  logic s_if = 0, s_id = 0, s_ex = 0, s_mem = 0;
  logic [31:0] excp = 0, epc = 0;
  logic [5:0] stall;
  logic flush, wdog_timeout;
  logic [31:0] new_pc, stall_cycles;
  int checks = 0, errors = 0;

  pipe_ctrl #(.EXC_VECTOR(VEC), .ERET_TYPE(ERET), .WDOG_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex),
    .stallreq_mem(s_mem), .excp_type(excp), .cp0_epc(epc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_cycles(stall_cycles), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending exception slot plus plain counters
  bit m_pend = 0;
  logic [31:0] m_type = 0, m_epc = 0;
  longint m_cycles = 0;
  int m_wd = 0;
  bit m_to = 0;
  logic [5:0] e_stall = 0;
  logic e_flush = 0;
  logic [31:0] e_pc = 0;

  always @(negedge clk) begin
    int lvl;
    e_stall = 0; e_flush = 0; e_pc = 0;
    if (!rst) begin
      if (m_pend || excp != 0) begin
        if (s_mem) e_stall = 6'd31;
        else begin
          e_flush = 1;
          e_pc = m_pend ? (m_type == ERET ? m_epc : VEC) : (excp == ERET ? epc : VEC);
        end
      end else begin
        lvl = s_mem ? 4 : s_ex ? 3 : s_id ? 2 : s_if ? 1 : 0;
        e_stall = lvl == 0 ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
      end
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    chk("stall_cycles", stall_cycles, 32'(m_cycles));
    chk("wdog_timeout", 32'(wdog_timeout), 32'(m_to));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_type = 0; m_epc = 0; m_cycles = 0; m_wd = 0; m_to = 0;
    end else begin
      if (m_pend && !s_mem) m_pend = 0;
      else if (!m_pend && excp != 0 && s_mem) begin
        m_pend = 1; m_type = excp; m_epc = epc;
      end
      if (e_stall[0] && m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (m_wd == LIM) m_to = 1;
      m_wd = (e_stall[0] && !e_flush) ? (m_wd < LIM ? m_wd + 1 : LIM) : 0;
    end
  end

  task automatic drive(input logic r, input logic i, input logic d, input logic e, input logic m,
                       input logic [31:0] t, input logic [31:0] p);
    @(posedge clk);
    #1;
    rst = r; s_if = i; s_id = d; s_ex = e; s_mem = m; excp = t; epc = p;
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_flush", 32'(flush), 0);
    chk("idle_cycles", stall_cycles, 0);
    chk("idle_wdog", 32'(wdog_timeout), 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    chk("prio_if_ex", 32'(stall), 32'h0f);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("prio_if", 32'(stall), 32'h03);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("prio_mem", 32'(stall), 32'h1f);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("prio_id", 32'(stall), 32'h07);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("cycles_4", stall_cycles, 4);
    drive(0, 0, 0, 0, 0, 32'h8, 32'h40);
    chk("exc_flush", 32'(flush), 1);
    chk("exc_pc", new_pc, 32'h20);
    chk("exc_stall", 32'(stall), 0);
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    chk("exc_after", 32'(flush), 0);
    drive(0, 0, 0, 0, 0, 32'he, 32'h1234);
    chk("eret_flush", 32'(flush), 1);
    chk("eret_pc", new_pc, 32'h1234);
    drive(0, 1, 0, 1, 0, 32'h8, 32'h1234);
    chk("b2b_flush", 32'(flush), 1);
    chk("b2b_stall", 32'(stall), 0);
    chk("b2b_pc", new_pc, 32'h20);
    drive(0, 0, 0, 0, 1, 32'h8, 32'h100);
    chk("def_stall", 32'(stall), 32'h1f);
    chk("def_noflush", 32'(flush), 0);
    drive(0, 1, 0, 0, 1, 0, 32'h200);
    drive(0, 0, 0, 0, 1, 0, 32'h200);
    chk("def_hold", 32'(stall), 32'h1f);
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    chk("def_flush", 32'(flush), 1);
    chk("def_pc", new_pc, 32'h20);
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    chk("def_after", 32'(flush), 0);
    drive(0, 0, 0, 0, 1, 32'he, 32'h300);
    drive(0, 0, 1, 0, 1, 32'h8, 32'h400);
    chk("pend_ignore", 32'(flush), 0);
    drive(0, 0, 0, 0, 1, 0, 32'h400);
    drive(0, 0, 0, 0, 0, 0, 32'h400);
    chk("deret_flush", 32'(flush), 1);
    chk("deret_pc", new_pc, 32'h300);
    drive(0, 0, 0, 0, 1, 32'h8, 32'h500);
    drive(1, 0, 0, 0, 1, 0, 32'h500);
    chk("rst_stall", 32'(stall), 0);
    drive(0, 0, 0, 0, 0, 0, 32'h500);
    chk("rst_noflush", 32'(flush), 0);
    chk("rst_cycles", stall_cycles, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wd_short", 32'(wdog_timeout), 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wd_set", 32'(wdog_timeout), 1);
    chk("wd_cycles", stall_cycles, 8);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wd_sticky", 32'(wdog_timeout), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wd_clear", 32'(wdog_timeout), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
